// File: rtl/parking_sensor_gen_if.sv
// Bundle of request and sensor-output signals for the A/B parking-gate generator.
// The master side issues requests; the slave side is the generator itself.
interface parking_sensor_gen_if #(
  parameter int CNT_W   = 8,
  parameter int DWELL_W = 8
);
  logic               req_enter;
  logic               req_exit;
  logic [DWELL_W-1:0] dwell;
  logic               A;
  logic               B;
  logic               busy;
  logic               dir;
  logic               done_tick;
  logic               rej_tick;
  logic [CNT_W-1:0]   occupancy;

  modport master (
    output req_enter, req_exit, dwell,
    input  A, B, busy, dir, done_tick, rej_tick, occupancy
  );

  modport slave (
    input  req_enter, req_exit, dwell,
    output A, B, busy, dir, done_tick, rej_tick, occupancy
  );
endinterface

// File: rtl/parking_sensor_gen.sv
// Two-beam A/B parking-gate sequence generator.
// Plays enter (00-10-11-01-00) or exit (00-01-11-10-00) with a programmable dwell
// per phase, and keeps the occupancy implied by the sequences it has completed.
// Every output is a register loaded from the value the next state implies, so the
// outputs line up with the state they describe and never glitch.
module parking_sensor_gen #(
  parameter int MAX_CARS = 255,
  parameter int CNT_W    = 8,
  parameter int DWELL_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  parking_sensor_gen_if.slave bus
);

  typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, GAP, DONE} state_t;

  localparam logic [CNT_W-1:0]   MAX_OCC = CNT_W'(MAX_CARS);
  localparam logic [DWELL_W-1:0] ONE_D   = DWELL_W'(1);
  localparam logic [CNT_W-1:0]   ONE_C   = CNT_W'(1);

  state_t             state_reg, state_next;
  logic [DWELL_W-1:0] dwell_reg, dwell_next;   // latched D = max(dwell, 1)
  logic [DWELL_W-1:0] cnt_reg, cnt_next;       // cycles left in the current phase, minus one
  logic               dir_reg, dir_next;
  logic [CNT_W-1:0]   occ_reg, occ_next;
  logic               a_reg, a_next;
  logic               b_reg, b_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               rej_reg, rej_next;
  logic [DWELL_W-1:0] dwell_eff;

  // Next-state, counter, occupancy and registered-output values.
  always_comb begin
    state_next = state_reg;
    dwell_next = dwell_reg;
    cnt_next   = cnt_reg;
    dir_next   = dir_reg;
    occ_next   = occ_reg;
    rej_next   = 1'b0;
    dwell_eff  = (bus.dwell == '0) ? ONE_D : bus.dwell;

    case (state_reg)
      IDLE: begin
        // Enter wins over exit; a refused enter does not fall through to exit.
        if (bus.req_enter) begin
          if (occ_reg < MAX_OCC) begin
            state_next = PH1;
            dir_next   = 1'b1;
            dwell_next = dwell_eff;
            cnt_next   = dwell_eff - ONE_D;
          end else begin
            rej_next = 1'b1;
          end
        end else if (bus.req_exit) begin
          if (occ_reg != '0) begin
            state_next = PH1;
            dir_next   = 1'b0;
            dwell_next = dwell_eff;
            cnt_next   = dwell_eff - ONE_D;
          end else begin
            rej_next = 1'b1;
          end
        end
      end
      PH1, PH2, PH3, GAP: begin
        if (cnt_reg == '0) begin
          cnt_next = dwell_reg - ONE_D;
          case (state_reg)
            PH1:     state_next = PH2;
            PH2:     state_next = PH3;
            PH3:     state_next = GAP;
            default: begin
              // Occupancy commits only when a sequence finishes its gap phase.
              state_next = DONE;
              occ_next   = dir_reg ? (occ_reg + ONE_C) : (occ_reg - ONE_C);
            end
          endcase
        end else begin
          cnt_next = cnt_reg - ONE_D;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
    done_next = (state_next == DONE);
    a_next    = 1'b0;
    b_next    = 1'b0;
    case (state_next)
      PH1: begin
        a_next = dir_next;
        b_next = ~dir_next;
      end
      PH2: begin
        a_next = 1'b1;
        b_next = 1'b1;
      end
      PH3: begin
        a_next = ~dir_next;
        b_next = dir_next;
      end
      default: begin
        a_next = 1'b0;
        b_next = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any sequence without touching occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      dwell_reg <= ONE_D;
      cnt_reg   <= '0;
      dir_reg   <= 1'b0;
      occ_reg   <= '0;
      a_reg     <= 1'b0;
      b_reg     <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      rej_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      dwell_reg <= dwell_next;
      cnt_reg   <= cnt_next;
      dir_reg   <= dir_next;
      occ_reg   <= occ_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      rej_reg   <= rej_next;
    end
  end

  assign bus.A         = a_reg;
  assign bus.B         = b_reg;
  assign bus.busy      = busy_reg;
  assign bus.dir       = dir_reg;
  assign bus.done_tick = done_reg;
  assign bus.rej_tick  = rej_reg;
  assign bus.occupancy = occ_reg;

endmodule

// File: tb/tb_parking_sensor_gen.sv
// Scoreboard bench for parking_sensor_gen: the driver's reference model pushes the
// expected outcome of each sampled request; a negedge monitor pops and checks it when
// the DUT pulses rej_tick or finishes a sequence, and decodes A/B into a loopback count.
module tb_parking_sensor_gen;
  localparam int MAX_CARS = 3;
  localparam int CNT_W    = 8;
  localparam int DWELL_W  = 8;

  typedef struct {
    bit is_rej;
    bit dir;
    int d;
    int occ;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  parking_sensor_gen_if #(.CNT_W(CNT_W), .DWELL_W(DWELL_W)) bus ();

  parking_sensor_gen #(
    .MAX_CARS(MAX_CARS),
    .CNT_W   (CNT_W),
    .DWELL_W (DWELL_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   model_occ = 0;
  int   model_wait = 0;
  int   mon_cyc = 0;
  exp_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, mon_cyc);
    end
  endtask

  // Reference model: one call per rising edge with the request levels driven into it.
  task automatic model_sample(input bit e, input bit x, input int dw);
    exp_t t;
    if (model_wait > 0) begin
      model_wait--;
      return;
    end
    if (!e && !x) return;
    t.cyc = mon_cyc + 1;
    t.dir = e;
    t.d   = (dw < 1) ? 1 : dw;
    if (e ? (model_occ < MAX_CARS) : (model_occ > 0)) begin
      model_occ  = model_occ + (e ? 1 : -1);
      t.is_rej   = 1'b0;
      model_wait = 4 * t.d + 1;
    end else begin
      t.is_rej = 1'b1;
    end
    t.occ = model_occ;
    sb.push_back(t);
  endtask

  task automatic step(input bit e, input bit x, input int dw);
    bus.req_enter = e;
    bus.req_exit  = x;
    bus.dwell     = DWELL_W'(dw);
    @(posedge clk);
    model_sample(e, x, dw);
    @(negedge clk);
  endtask

  task automatic drain();
    while (model_wait > 0) step(1'b0, 1'b0, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_A"}, bus.A, 0);
    chk({tag, "_B"}, bus.B, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done_tick, 0);
    chk({tag, "_rej"}, bus.rej_tick, 0);
    chk({tag, "_occ"}, int'(bus.occupancy), 0);
  endtask

  // ---------------- monitor ----------------
  logic [1:0] trace[$];
  logic [1:0] prev_ab = 2'b00, first_ab = 2'b00, last_ab = 2'b00;
  int         lb = 0;
  bit         in_seq = 1'b0;
  int         start_cyc = 0;

  function automatic int trace_err(input bit d_enter, input int d);
    logic [1:0] p[4];
    if (d_enter) p = '{2'b10, 2'b11, 2'b01, 2'b00};
    else         p = '{2'b01, 2'b11, 2'b10, 2'b00};
    if (trace.size() != 4 * d + 1) return -2;
    for (int i = 0; i < 4 * d; i++)
      if (trace[i] != p[i / d]) return i;
    if (trace[4 * d] != 2'b00) return 4 * d;
    return -1;
  endfunction

  always @(negedge clk) begin
    logic [1:0] ab;
    exp_t e;
    mon_cyc++;
    ab = {bus.A, bus.B};
    if (!rst) begin
      in_seq  = 1'b0;
      trace.delete();
      prev_ab = 2'b00;
      lb      = 0;
    end else begin
      // Loopback occupancy counter decoding the beam pattern.
      if (ab != 2'b00) begin
        if (prev_ab == 2'b00) first_ab = ab;
        last_ab = ab;
      end else if (prev_ab != 2'b00) begin
        if (first_ab == 2'b10 && last_ab == 2'b01) lb++;
        else if (first_ab == 2'b01 && last_ab == 2'b10) lb--;
      end
      prev_ab = ab;

      if (bus.rej_tick) begin
        chk("rej_while_busy", bus.busy, 0);
        chk("rej_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          $display("[TB] rej   cyc=%0d occ=%0d", mon_cyc, bus.occupancy);
          chk("rej_kind", 1, e.is_rej);
          chk("rej_cycle", mon_cyc, e.cyc);
          chk("rej_occ", int'(bus.occupancy), e.occ);
        end
      end

      if (bus.busy) begin
        if (!in_seq) begin
          in_seq    = 1'b1;
          start_cyc = mon_cyc;
          trace.delete();
        end
        trace.push_back(ab);
        if (bus.done_tick) begin
          in_seq = 1'b0;
          chk("seq_expected", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            $display("[TB] seq   dir=%0d D=%0d occ=%0d start=%0d", bus.dir, e.d, bus.occupancy, start_cyc);
            chk("seq_kind", 0, e.is_rej);
            chk("seq_start_cycle", start_cyc, e.cyc);
            chk("busy_len", trace.size(), 4 * e.d + 1);
            chk("ab_trace", trace_err(e.dir, e.d), -1);
            chk("dir", bus.dir, e.dir);
            chk("occ_done", int'(bus.occupancy), e.occ);
            chk("loopback_occ", lb, e.occ);
          end
        end
      end else begin
        chk("idle_ab", ab, 0);
        chk("done_outside_busy", bus.done_tick, 0);
        chk("seq_cut_short", in_seq, 0);
        in_seq = 1'b0;
      end
    end
  end

  // ---------------- driver ----------------
  initial begin
    bus.req_enter = 1'b0;
    bus.req_exit  = 1'b0;
    bus.dwell     = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    chk("por_dir", bus.dir, 0);
    rst = 1'b1;
    @(negedge clk);

    // enter with dwell 2, then exit with dwell 0 (treated as 1)
    step(1'b1, 1'b0, 2); drain();
    step(1'b0, 1'b1, 0); drain();
    // exit at empty is refused
    step(1'b0, 1'b1, 5); step(1'b0, 1'b0, 0);
    chk("empty_occ", int'(bus.occupancy), 0);
    // held enter fills to the ceiling then refuses every cycle
    repeat (24) step(1'b1, 1'b0, 1);
    step(1'b0, 1'b0, 0);
    // both requests at occupancy 2: enter wins; exit held while busy is ignored
    step(1'b0, 1'b1, 1); drain();
    step(1'b1, 1'b1, 2);
    repeat (8) step(1'b0, 1'b1, 1);
    step(1'b0, 1'b0, 0);
    chk("occ_after_both", int'(bus.occupancy), 3);

    // reset during PH2 of an enter sequence
    step(1'b0, 1'b1, 1); drain();
    step(1'b1, 1'b0, 3);
    repeat (4) step(1'b0, 1'b0, 0);
    chk("ph2_ab", {bus.A, bus.B}, 2'b11);
    #2 rst = 1'b0;
    #1;
    chk_reset_outputs("mid");
    sb.delete();
    model_occ  = 0;
    model_wait = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 1'b0, 1); drain();

    // randomized requests
    for (int i = 0; i < 100; i++) begin
      int k, dw, h;
      k  = $urandom_range(0, 3);
      dw = $urandom_range(0, 3);
      h  = $urandom_range(1, 3);
      repeat (h) step(k[0], k[1], dw);
      if ($urandom_range(0, 1) == 1) drain();
    end
    drain();
    repeat (3) step(1'b0, 1'b0, 0);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/parking_sensor_gen.md
# parking_sensor_gen

Synthesizable driver for the two-beam A/B parking-gate sensor interface. On an enter or exit request it plays the full gate sequence on A/B: enter is 00→10→11→01→00 and exit is 00→01→11→10→00, with a programmable dwell per phase. It also tracks the occupancy it has produced, so it can refuse impossible requests. It drives occupancy-counter hardware in board-level self-test and serves as the stimulus source in simulation benches.

## Interface
- MAX_CARS, default 255: occupancy ceiling; an enter request is refused when occupancy == MAX_CARS.
- CNT_W, default 8: occupancy width; must satisfy 2^CNT_W > MAX_CARS.
- DWELL_W, default 8: width of the dwell input.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_enter  in  1  level request to generate one entering car.
- req_exit  in  1  level request to generate one exiting car.
- dwell  in  DWELL_W  cycles per phase; sampled only when a request is accepted.
- A  out  1  sensor A beam, registered.
- B  out  1  sensor B beam, registered.
- busy  out  1  high from acceptance through the DONE cycle.
- dir  out  1  direction of the current or last sequence: 1 = enter, 0 = exit.
- done_tick  out  1  one-cycle pulse when a sequence completes.
- rej_tick  out  1  one-cycle pulse when a request is refused.
- occupancy  out  CNT_W  cars currently inside, per the generated sequences.

## Operation
- States: IDLE, PH1, PH2, PH3, GAP, DONE.
- A/B values per state:
  - IDLE, GAP, DONE: 00 in both directions.
  - Enter: PH1 = 10, PH2 = 11, PH3 = 01.
  - Exit: PH1 = 01, PH2 = 11, PH3 = 10.
- IDLE samples requests every cycle:
  - req_enter has priority when both are high.
  - Enter is accepted if occupancy < MAX_CARS; exit is accepted if occupancy > 0.
- On acceptance:
  - Latch D = max(dwell, 1); dwell = 0 is treated as 1.
  - Latch dir.
  - Load the phase counter with D−1 and go to PH1.
- On refusal: rej_tick = 1 in the next cycle and the block stays in IDLE. A refused enter does **not** fall through to a simultaneous exit.
- PH1, PH2, PH3 and GAP each last exactly D cycles. The counter decrements to 0, then advances to the next state and reloads D−1.
- The edge leaving GAP enters DONE and updates occupancy: +1 for enter, −1 for exit.
  - No wrap is possible because of the acceptance checks.
- DONE lasts one cycle with done_tick = 1, then returns to IDLE.
- Requests are ignored in every state except IDLE; nothing is queued.
- A request held high generates back-to-back cars, with at least one IDLE cycle between sequences.
- The transition between phases changes exactly one of A/B, so every sequence is Gray-coded and glitch-free.
- Reset (asynchronous, any time, including mid-sequence):
  - State = IDLE.
  - A = B = 0, busy = 0, dir = 0, done_tick = 0, rej_tick = 0, occupancy = 0.
  - An aborted sequence never modifies occupancy.

## Timing
- Request sampled high in IDLE at edge N; all outputs are registered.
- Accepted sequence:
  - A/B show the PH1 value and busy = 1 in cycles N+1 … N+D.
  - PH2 in cycles N+D+1 … N+2D.
  - PH3 in cycles N+2D+1 … N+3D.
  - GAP (00) in cycles N+3D+1 … N+4D.
  - DONE in cycle N+4D+1: done_tick = 1 and the new occupancy is visible.
  - IDLE in cycle N+4D+2: busy = 0, and a new request is sampled at the edge ending that cycle.
- Total busy time is 4D+1 cycles.
- Refused request: rej_tick high in cycle N+1 only, busy stays 0, A/B stay 00. A held refused request pulses rej_tick every cycle.
- dir updates at acceptance and holds through the sequence and the following IDLE.
- Occupancy changes only on the IDLE→… path through DONE, once per sequence.

## Test plan
- Reset, dwell = 2, req_enter pulsed 1 cycle -> A/B = 10,10,11,11,01,01,00,00; then DONE with done_tick = 1 and occupancy = 1; busy high for 9 cycles; dir = 1.
- From occupancy = 1, dwell = 0, req_exit -> A/B = 01,11,10,00, each for 1 cycle; done_tick; occupancy = 0; busy high for 5 cycles.
- occupancy = 0, req_exit -> rej_tick for 1 cycle; A/B stay 00; busy = 0; occupancy = 0.
- MAX_CARS = 3, req_enter held with dwell = 1 -> three complete enter sequences, each separated by ≥ 1 IDLE cycle; occupancy goes 1, 2, 3; then rej_tick every cycle while the request is held.
- req_enter and req_exit asserted together with occupancy = 2 -> enter sequence generated, occupancy = 3; exit is ignored. A request arriving while busy is ignored.
- rst asserted during PH2 of an enter -> A = B = 0 and busy = 0 immediately, with no done_tick; after release occupancy = 0 and a new request is accepted normally. A loopback into the A/B occupancy counter tracks occupancy exactly over 100 random enter/exit requests.
